// File: rtl/sklansky_pkg.sv
// Shared types and constants for the Sklansky parallel-prefix adder.
// Build option: define SKL_CIN_EN to add a carry-in port to the adder.
package sklansky_pkg;

   localparam int SKL_WIDTH  = 16;
   localparam int SKL_LEVELS = $clog2(SKL_WIDTH);

   typedef logic [SKL_WIDTH-1:0] skl_word_t;

   typedef struct packed {
      logic p;
      logic g;
   } skl_pg_t;

   // Index of the topmost bit of the lower neighbouring block of size 2^(k-1)
   // that bit i pairs with at prefix level k.
   function automatic int skl_block_top(input int i, input int k);
      return ((i >> (k - 1)) << (k - 1)) - 1;
   endfunction

endpackage

// File: rtl/sklansky_prefix_cell.sv
// Prefix operator: merges a high (left) group with the adjacent low (right) group.
// Build option: none (SKL_CIN_EN only affects the top level).
module sklansky_prefix_cell (
   input  logic pr,
   input  logic gr,
   input  logic pl,
   input  logic gl,
   output logic po,
   output logic go
);

   assign go = gl | (pl & gr);
   assign po = pl & pr;

endmodule

// File: rtl/sklansky_adder_16.sv
// Registered unsigned adder on a Sklansky prefix tree, one cycle of latency.
// Build option: define SKL_CIN_EN to add the ci port (result = A + B + ci).
module sklansky_adder_16
   import sklansky_pkg::*;
#(
   parameter int WIDTH = SKL_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef SKL_CIN_EN
   input  logic             ci,
`endif
   output logic             out_valid,
   output logic [WIDTH-1:0] SUM,
   output logic             CO
);

   localparam int LEVELS = $clog2(WIDTH);

   logic             cin;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum_d;
   logic             co_d;

   // tree[k][i] holds the group (p,g) of bits [block start .. i] after level k;
   // the last level therefore spans [0 .. i].
   skl_pg_t tree [LEVELS+1][WIDTH];

`ifdef SKL_CIN_EN
   assign cin = ci;
`else
   assign cin = 1'b0;
`endif

   // Carry-in behaves like a generate at position -1, so it folds into g_0.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lsb
         assign tree[0][i] = '{p: A[i] | B[i],
                               g: (A[i] & B[i]) | ((A[i] | B[i]) & cin)};
      end else begin : g_upper
         assign tree[0][i] = '{p: A[i] | B[i], g: A[i] & B[i]};
      end
   end

   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      for (genvar i = 0; i < WIDTH; i++) begin : g_col
         if (((i >> (k - 1)) & 1) == 1) begin : g_cell
            localparam int J = skl_block_top(i, k);
            sklansky_prefix_cell u_cell (
               .pr (tree[k-1][J].p),
               .gr (tree[k-1][J].g),
               .pl (tree[k-1][i].p),
               .gl (tree[k-1][i].g),
               .po (tree[k][i].p),
               .go (tree[k][i].g)
            );
         end else begin : g_pass
            assign tree[k][i] = tree[k-1][i];
         end
      end
   end

   assign carry[0] = cin;
   for (genvar i = 1; i < WIDTH; i++) begin : g_carry
      assign carry[i] = tree[LEVELS][i-1].g;
   end

   assign sum_d = A ^ B ^ carry;
   assign co_d  = tree[LEVELS][WIDTH-1].g;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         SUM       <= '0;
         CO        <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            SUM <= sum_d;
            CO  <= co_d;
         end
      end
   end

endmodule

// File: tb/tb_sklansky_adder_16.sv
// Self-checking bench for sklansky_adder_16: directed table, sequences, random.
// Build option: define SKL_CIN_EN for both RTL and bench to exercise ci.
module tb_sklansky_adder_16;
   import sklansky_pkg::*;

   logic      clk;
   logic      rst_n;
   logic      in_valid;
   skl_word_t a;
   skl_word_t b;
   logic      ci;
   logic      out_valid;
   skl_word_t sum;
   logic      co;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      skl_word_t a;
      skl_word_t b;
      logic      ci;
      skl_word_t exp_sum;
      logic      exp_co;
   } vec_t;

   vec_t vecs[$];

   sklansky_adder_16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (a),
      .B         (b),
`ifdef SKL_CIN_EN
      .ci        (ci),
`endif
      .out_valid (out_valid),
      .SUM       (sum),
      .CO        (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic check_out(input string name, input logic exp_v,
                            input skl_word_t exp_sum, input logic exp_co);
      check({name, ".valid"}, 32'(out_valid), 32'(exp_v));
      check({name, ".sum"},   32'(sum),       32'(exp_sum));
      check({name, ".co"},    32'(co),        32'(exp_co));
   endtask

   task automatic drive(input logic v, input skl_word_t va, input skl_word_t vb,
                        input logic vci);
      in_valid = v;
      a        = va;
      b        = vb;
`ifdef SKL_CIN_EN
      ci       = vci;
`else
      ci       = 1'b0;
      if (vci) ci = 1'b0;
`endif
   endtask

   // Reference: plain arithmetic on a 17-bit result.
   function automatic logic [SKL_WIDTH:0] model(input skl_word_t ma, input skl_word_t mb,
                                                input logic mci);
      return {1'b0, ma} + {1'b0, mb} + {{SKL_WIDTH{1'b0}}, mci};
   endfunction

   initial begin
      logic [SKL_WIDTH:0] r;
      skl_word_t          exp_sum;
      logic               exp_co;
      logic               exp_v;

      vecs.push_back('{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0});
      vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0});
      vecs.push_back('{16'h00FF, 16'h0000, 1'b0, 16'h00FF, 1'b0});
      vecs.push_back('{16'h00FF, 16'h8000, 1'b0, 16'h80FF, 1'b0});
      vecs.push_back('{16'h00FF, 16'hAAAA, 1'b0, 16'hABA9, 1'b0});
      vecs.push_back('{16'h00FF, 16'h5555, 1'b0, 16'h5654, 1'b0});
      vecs.push_back('{16'h001F, 16'h0010, 1'b0, 16'h002F, 1'b0});
      vecs.push_back('{16'h001F, 16'hE9E0, 1'b0, 16'hE9FF, 1'b0});
      vecs.push_back('{16'h3E5E, 16'hE9E0, 1'b0, 16'h283E, 1'b1});
      vecs.push_back('{16'h3E5E, 16'hFFFF, 1'b0, 16'h3E5D, 1'b1});
      vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
`ifdef SKL_CIN_EN
      vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1});
      vecs.push_back('{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1});
`endif

      // Reset held with a valid all-ones operation presented.
      rst_n = 1'b0;
      drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      repeat (3) @(posedge clk);
      #1 check_out("reset_hold", 1'b0, 16'h0000, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 16'h0000, 16'h0000, 1'b0);
      #1 check_out("post_release", 1'b0, 16'h0000, 1'b0);
      @(posedge clk);
      #1 check_out("first_op", 1'b1, 16'h0000, 1'b0);

      // Directed table, back to back; outputs must still show the previous
      // result until the edge that samples the new operands.
      exp_sum = 16'h0000;
      exp_co  = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci);
         #1 check_out($sformatf("vec%0d_pre", i), 1'b1, exp_sum, exp_co);
         @(posedge clk);
         #1 check_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_sum, vecs[i].exp_co);
         exp_sum = vecs[i].exp_sum;
         exp_co  = vecs[i].exp_co;
      end

      // in_valid 1,0,1: result holds through the bubble.
      @(negedge clk);
      drive(1'b1, 16'h1234, 16'h4321, 1'b0);
      @(posedge clk);
      #1 check_out("bubble_a", 1'b1, 16'h5555, 1'b0);
      @(negedge clk);
      drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
      @(posedge clk);
      #1 check_out("bubble_hold", 1'b0, 16'h5555, 1'b0);
      @(negedge clk);
      drive(1'b1, 16'h8000, 16'h8000, 1'b0);
      @(posedge clk);
      #1 check_out("bubble_b", 1'b1, 16'h0000, 1'b1);

      // Asynchronous reset mid-cycle clears outputs before the next edge.
      @(negedge clk);
      drive(1'b1, 16'hF0F0, 16'h0F0F, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_out("async_clear", 1'b0, 16'h0000, 1'b0);
      @(negedge clk);
      drive(1'b1, 16'hAAAA, 16'h5555, 1'b0);
      @(posedge clk);
      #1 check_out("inflight_drop", 1'b0, 16'h0000, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 16'h1234, 16'h1111, 1'b0);
      #1 check_out("release_cycle", 1'b0, 16'h0000, 1'b0);
      @(posedge clk);
      #1 check_out("after_release", 1'b1, 16'h2345, 1'b0);

      // Random stream against the arithmetic model.
      exp_sum = 16'h2345;
      exp_co  = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         logic      rv;
         skl_word_t ra;
         skl_word_t rb;
         logic      rc;
         rv = ($urandom_range(0, 7) != 0);
         ra = skl_word_t'($urandom);
         rb = skl_word_t'($urandom);
`ifdef SKL_CIN_EN
         rc = 1'($urandom_range(0, 1));
`else
         rc = 1'b0;
`endif
         @(negedge clk);
         drive(rv, ra, rb, rc);
         exp_v = rv;
         if (rv) begin
            r       = model(ra, rb, rc);
            exp_sum = r[SKL_WIDTH-1:0];
            exp_co  = r[SKL_WIDTH];
         end
         @(posedge clk);
         #1 check_out("rand", exp_v, exp_sum, exp_co);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sklansky_adder_16.md
Name: sklansky_adder_16

Overview:
- Registered 16-bit unsigned adder built on a Sklansky (divide-and-conquer) parallel-prefix carry tree.
- Computes {CO,SUM} = A + B (+ optional carry-in) with one cycle of latency.
- Datapath arithmetic leaf inside the arithmetic cluster. Fed by upstream pipeline registers; result consumed by downstream logic via a valid strobe.

Parameters:
- WIDTH, 16, operand width. Must be a power of two ≥ 2. Prefix depth = log2(WIDTH) levels (4 for 16).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  A/B (and ci) are valid this cycle
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- ci  input  1  carry-in; present only with SKL_CIN_EN
- out_valid  output  1  SUM/CO valid
- SUM  output  WIDTH  (A+B+ci) mod 2^WIDTH
- CO  output  1  carry-out, bit WIDTH of the full sum

Behaviour:
- Reset:
  - Asynchronous on rst_n low: SUM=0, CO=0, out_valid=0 immediately, independent of clk.
  - Release is synchronous to clk.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on SUM/CO/out_valid after edge N.
- Load rule:
  - in_valid=1: SUM/CO load the new result; out_valid<=1.
  - in_valid=0: out_valid<=0; SUM/CO hold their previous values.
  - No backpressure: a new operation is accepted every cycle.
- Bit-level signals:
  - Per bit i: g_i = A_i & B_i; p_i = A_i | B_i. Inclusive OR is acceptable because the sum uses a separate XOR.
  - Bit 0 with SKL_CIN_EN: g_0 = A_0&B_0 | (A_0|B_0)&ci.
- Prefix cell combines a right (low) pair (pr,gr) with a left (high) pair (pl,gl):
  - go = gl | (pl & gr)
  - po = pl & pr
- Sklansky tree: at level k (k=1..log2 WIDTH), every bit whose index has bit (k-1) set combines with the group output ending at the top of the adjacent lower block of size 2^(k-1).
- Fan-out at the last level is WIDTH/2 from a single node (bit 7 for WIDTH=16). This is accepted.
- Sum and carry:
  - carry into bit i = group generate over bits [i-1:0].
  - SUM_i = A_i ^ B_i ^ carry_i.
  - SUM_0 = A_0 ^ B_0 (^ ci when enabled).
  - CO = group generate over [WIDTH-1:0].
- Boundaries:
  - Full wrap, e.g. FFFF+0001 → SUM=0000, CO=1.
  - Maximum, FFFF+FFFF → SUM=FFFE, CO=1.
  - 0+0 → SUM=0000, CO=0.
  - Reset asserted mid-stream drops the in-flight result; out_valid is 0 on the first cycle after release.
- Behavioural '+' in the datapath is forbidden. The prefix network is explicit; '+' is allowed only in the verification model.

Optional Feature:
- Macro: SKL_CIN_EN.
- Defined: ci port exists and is folded into g_0 (equivalent to prefix position -1); result = A+B+ci.
- Undefined: no ci port; carry-in is constant 0; result = A+B.
- Latency and reset behaviour are identical in both builds.

Decomposition:
- Package sklansky_pkg:
  - localparam SKL_WIDTH=16 and SKL_LEVELS=$clog2(SKL_WIDTH).
  - typedef skl_word_t = logic [SKL_WIDTH-1:0].
  - typedef skl_pg_t struct {p,g}.
- One sub-module, sklansky_prefix_cell: the combinational (pr,gr,pl,gl)→(po,go) operator, instantiated by generate loops per level.
- The top level contains the generate tree, sum XORs, output registers and the valid pipeline.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, A=FFFF, B=FFFF → SUM=0000, CO=0, out_valid=0. Release, then drive 0+0 → SUM=0000, CO=0, out_valid=1 one cycle later.
- A=00FF, B=0001 → SUM=0100, CO=0. Then B=0000 → 00FF. Then B=8000 → 80FF, CO=0. Each appears exactly one cycle after the sample.
- A=00FF with B=AAAA → ABA9, CO=0. B=5555 → 5654, CO=0. Then A=001F, B=0010 → 002F. Then B=E9E0 → E9FF, CO=0.
- A=3E5E, B=E9E0 → SUM=283E, CO=1. B=FFFF → SUM=3E5D, CO=1. FFFF+0001 → 0000, CO=1. Covers full carry ripple across all four levels.
- in_valid toggling 1,0,1: out_valid follows one cycle later. SUM holds during the bubble. Assert rst_n low asynchronously mid-cycle → outputs clear before the next edge.
- With SKL_CIN_EN: FFFF+0000+ci=1 → 0000, CO=1; 7FFF+0000+1 → 8000, CO=0. Finish with 10k random vectors against a behavioural A+B+ci model.
